mem_access_ctrl: RTL

Bus-master controller that drives the 16×8 data memory's `w`/`r`/`address`/`dataIn` pins and captures `dataOut`. It is the initiator end of the memory interface. It sits between the CPU load/store path and the memory. It accepts single writes and 1–16 beat burst reads through a valid/ready request port, and returns one response beat per read address through a valid/ready response port.

---
 rtl/mem_access_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for the 16x8 data memory: single writes and 1..16 beat
// burst reads, one response beat per read address with at most one beat outstanding.
module mem_access_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [3:0]        req_len,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              mem_w,
    output logic              mem_r,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

    localparam int LAT_W = 2;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] cur_addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [3:0]        beats_left_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic [ADDR_W-1:0] rsp_addr_reg;
    logic [DATA_W-1:0] rsp_data_reg;

    // The address/data pins are the working registers themselves, so they hold between accesses.
    assign mem_address = cur_addr_reg;
    assign mem_dataIn  = wdata_reg;
    assign rsp_addr    = rsp_addr_reg;
    assign rsp_data    = rsp_data_reg;

    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        mem_w      = 1'b0;
        mem_r      = 1'b0;
        rsp_valid  = 1'b0;
        busy       = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) begin
                    state_next = req_we ? WRITE : READ;
                end
            end
            WRITE: begin
                mem_w      = 1'b1;
                state_next = IDLE;
            end
            READ: begin
                mem_r      = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (lat_cnt_reg == '0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = (beats_left_reg == 4'd0) ? IDLE : READ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            cur_addr_reg   <= '0;
            wdata_reg      <= '0;
            beats_left_reg <= '0;
            lat_cnt_reg    <= '0;
            rsp_addr_reg   <= '0;
            rsp_data_reg   <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        cur_addr_reg   <= req_addr;
                        beats_left_reg <= req_len;
                        // Write data only moves on writes so mem_dataIn stays quiet during reads.
                        if (req_we) begin
                            wdata_reg <= req_wdata;
                        end
                    end
                end
                READ: begin
                    lat_cnt_reg <= LAT_W'(RD_LAT - 1);
                end
                WAIT: begin
                    if (lat_cnt_reg == '0) begin
                        rsp_data_reg <= mem_dataOut;
                        rsp_addr_reg <= cur_addr_reg;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready && beats_left_reg != 4'd0) begin
                        cur_addr_reg   <= cur_addr_reg + 1'b1;
                        beats_left_reg <= beats_left_reg - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
